// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-length burst from a 1-cycle-latency sync FIFO onto a valid/ready stream
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                state;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  fire;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign dn_valid = (buf_count != 2'd0);
  assign dn_data  = mem[rd_ptr];
  assign fire     = dn_valid & dn_ready;
  // in-flight word counts against buffer space; a same-cycle fire frees one slot
  assign fifo_pop = (state == RUN) & ~fifo_empty & (issued != len_q) &
                    ({1'b0, buf_count} + {2'b0, inflight} < 3'd2 + {2'b0, fire});
  // burst FSM, pop/transfer counters and 2-entry skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      xfer_cnt  <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      mem[0]    <= '0;
      mem[1]    <= '0;
    end else begin
      inflight <= fifo_pop;
      case (state)
        IDLE: if (start) begin
          len_q <= length;
          if (length == '0) state <= DONE;
          else begin
            issued    <= '0;
            xfer_cnt  <= '0;
            buf_count <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (fifo_pop) issued <= issued + CNT_WIDTH'(1);
          if (inflight) begin
            mem[wr_ptr] <= fifo_data;
            wr_ptr      <= ~wr_ptr;
          end
          if (fire) begin
            rd_ptr   <= ~rd_ptr;
            xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            if (xfer_cnt + CNT_WIDTH'(1) == len_q) state <= DONE;
          end
          buf_count <= buf_count + {1'b0, inflight} - {1'b0, fire};
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of burst draining against a behavioural sync FIFO
module tb_fifo_stream_reader;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] length = 0;
  logic        busy, done, fifo_pop, dn_valid;
  logic [15:0] xfer_cnt, dn_data;
  logic        fifo_empty = 1;
  logic [15:0] fifo_data = 0;
  logic        dn_ready = 1;
  logic        push = 0;
  logic [15:0] push_data = 0;
  logic [15:0] fq [$];
  logic [15:0] rx [$];
  logic [5:0]  pat = 6'b101001;
  int checks = 0, errors = 0, cyc = 0, pops = 0, viol = 0, stall_err = 0, last_fire = 0;
  logic        prev_stall = 0;
  logic [15:0] prev_data = 0;
  int          dc, c0;

  fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .busy(busy), .done(done),
    .xfer_cnt(xfer_cnt), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (fifo_pop && fq.size() != 0) fifo_data <= fq.pop_front();
    if (push) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_pop) pops++;
      if (fifo_pop && fifo_empty) viol++;
      if (32'(dut.buf_count) + 32'(dut.inflight) > 2) viol++;
      if (fifo_pop && 32'(dut.buf_count) + 32'(dut.inflight) == 2 && !(dn_valid && dn_ready)) viol++;
      if (prev_stall && (!dn_valid || dn_data !== prev_data)) stall_err++;
      if (dn_valid && dn_ready) begin
        rx.push_back(dn_data);
        last_fire = cyc;
      end
      prev_stall = dn_valid && !dn_ready;
      prev_data  = dn_data;
    end else prev_stall = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      push = 1;
      push_data = 16'(base + k);
      tick();
    end
    push = 0;
    tick();
  endtask

  task automatic chk_rx(input string tag, input int base, input int n);
    chk({tag, "_n"}, rx.size(), n);
    for (int k = 0; k < n && k < rx.size(); k++) chk(tag, rx[k], base + k);
  endtask

  // mode 0: always ready, 1: ready pattern, 2: starved FIFO, 3: start pulsed mid-run
  task automatic burst(input int len, input int mode, output int dcyc);
    int pushed = 0;
    dcyc = -1;
    rx.delete();
    pops = 0;
    start = 1;
    length = 16'(len);
    for (int i = 0; i < 200; i++) begin
      dn_ready = (mode == 1) ? pat[i % 6] : 1'b1;
      push = (mode == 2 && i % 3 == 0 && pushed < 4);
      push_data = 16'(16'h21 + pushed);
      if (push) pushed++;
      if (mode == 3 && i == 2) begin
        start = 1;
        length = 16'd1;
      end
      tick();
      start = 0;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    push = 0;
    dn_ready = 1;
    if (dcyc < 0) chk("timeout", 0, 1);
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", dn_valid, 0);
    chk("rst_data", dn_data, 0);

    load(1, 8);
    rx.delete();
    pops = 0;
    start = 1;
    length = 8;
    tick();
    start = 0;
    chk("c1_busy", busy, 1);
    chk("c1_pop", fifo_pop, 1);
    tick();
    chk("c2_valid", dn_valid, 0);
    tick();
    chk("c3_valid", dn_valid, 1);
    chk("c3_data", dn_data, 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("cont_valid", dn_valid, 1);
      chk("cont_data", dn_data, k);
    end
    tick();
    chk("c11_done", done, 1);
    chk("c11_busy", busy, 0);
    chk("c11_xfer", xfer_cnt, 8);
    tick();
    chk("c12_done", done, 0);
    chk("cont_fq", fq.size(), 0);
    chk("cont_pops", pops, 8);
    chk_rx("cont_rx", 1, 8);

    load(16'h11, 6);
    burst(6, 1, dc);
    chk("bp_done_lat", dc - last_fire, 1);
    chk("bp_xfer", xfer_cnt, 6);
    tick();
    chk_rx("bp_rx", 16'h11, 6);
    chk("bp_pops", pops, 6);

    burst(4, 2, dc);
    tick();
    chk("st_pops", pops, 4);
    chk_rx("st_rx", 16'h21, 4);

    load(16'h31, 10);
    burst(3, 0, dc);
    tick();
    chk("pd_pops", pops, 3);
    chk("pd_fq", fq.size(), 7);
    chk_rx("pd_rx", 16'h31, 3);
    burst(7, 0, dc);
    tick();
    chk("pd2_pops", pops, 7);
    chk("pd2_fq", fq.size(), 0);
    chk_rx("pd2_rx", 16'h34, 7);

    load(16'h55, 4);
    c0 = cyc;
    burst(0, 0, dc);
    chk("zl_lat", dc - c0, 1);
    chk("zl_busy", busy, 0);
    chk("zl_pop", fifo_pop, 0);
    chk("zl_xfer", xfer_cnt, 7);
    tick();
    chk("zl_pops", pops, 0);
    chk("zl_fq", fq.size(), 4);
    burst(4, 3, dc);
    chk("ig_xfer", xfer_cnt, 4);
    tick();
    chk_rx("ig_rx", 16'h55, 4);

    load(16'h71, 5);
    rx.delete();
    start = 1;
    length = 5;
    tick();
    start = 0;
    for (int i = 0; i < 20 && xfer_cnt != 2; i++) tick();
    chk("rb_mid", xfer_cnt, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("rb_valid", dn_valid, 0);
    chk("rb_busy", busy, 0);
    chk("rb_xfer", xfer_cnt, 0);
    chk("rb_pop", fifo_pop, 0);
    chk("rb_data", dn_data, 0);
    fq.delete();
    tick();
    load(16'h81, 3);
    burst(3, 0, dc);
    chk("rb2_xfer", xfer_cnt, 3);
    tick();
    chk_rx("rb2_rx", 16'h81, 3);

    chk("viol", viol, 0);
    chk("stall", stall_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
